// File: rtl/ahb_master.sv
// ahb_master: single-outstanding AHB-Lite master bridging a valid/ready
// command/response interface onto one NONSEQ single transfer at a time.
//
// Optional feature: define AHB_MASTER_TIMEOUT_EN to abort a transfer after
// TIMEOUT_CYCLES consecutive HREADY-low cycles in the address or data phase.
// Without it the block waits indefinitely for HREADY.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only when idle)
//   cmd_addr/write/wdata  byte address, direction, write data
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata/rsp_err     read data (0 on writes/errors), error flag
//   HADDR/HWRITE/HWDATA   registered AHB address, direction, write data
//   HTRANS                IDLE (2'b00) or NONSEQ (2'b10) only
//   HRDATA/HREADY/HRESP   AHB slave read data, ready, error response
module ahb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic        cmd_write,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  output logic [1:0]  HTRANS,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  state_t      state;
  logic [31:0] wdata_q;   // write data held from acceptance to the data phase
  logic        err_q;     // HRESP seen on an earlier stalled data cycle

`ifdef AHB_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt;
`endif

  assign cmd_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      HTRANS    <= 2'b00;
      HADDR     <= '0;
      HWRITE    <= 1'b0;
      HWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef AHB_MASTER_TIMEOUT_EN
      tmo_cnt   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_addr[1:0] == 2'b00) begin
              state   <= S_ADDR;
              HTRANS  <= 2'b10;
              HADDR   <= cmd_addr;
              HWRITE  <= cmd_write;
              wdata_q <= cmd_write ? cmd_wdata : '0;
              err_q   <= 1'b0;
            end else begin
              // Misaligned: never touches the bus, answers with an error.
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end
          end
        end

        S_ADDR: begin
          if (HREADY) begin
            state  <= S_DATA;
            HTRANS <= 2'b00;
            HWDATA <= wdata_q;
`ifdef AHB_MASTER_TIMEOUT_EN
            tmo_cnt <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= S_RESP;
            HTRANS    <= 2'b00;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            tmo_cnt   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
          end
        end

        S_DATA: begin
          if (HREADY) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            // Error covers both cycles of the two-cycle error response.
            rsp_err   <= err_q | HRESP;
            rsp_rdata <= (HWRITE || err_q || HRESP) ? '0 : HRDATA;
`ifdef AHB_MASTER_TIMEOUT_EN
            tmo_cnt   <= '0;
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            tmo_cnt   <= '0;
`endif
          end else begin
            err_q <= err_q | HRESP;
`ifdef AHB_MASTER_TIMEOUT_EN
            tmo_cnt <= tmo_cnt + 1'b1;
`endif
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master.sv
// tb_ahb_master: randomized and directed checks of ahb_master against a
// timeline model. Each transaction is planned up front (address-phase stall,
// data-phase stall, response hold, HRESP pattern), so the cycle in which
// every phase must start follows from plain arithmetic.
module tb_ahb_master;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [1:0]  HTRANS;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  always #5 clk = ~clk;

  ahb_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HWRITE(HWRITE), .HWDATA(HWDATA), .HTRANS(HTRANS),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  int checks = 0;
  int errors = 0;

  // Model of the address/direction the bus must currently be holding.
  logic [31:0] m_haddr;
  logic        m_hwrite;

  // Observations of the last transaction, pinned by literal expectations.
  int          obs_lat;
  int          obs_trans;
  int          obs_valid;
  logic [31:0] obs_rdata;
  logic        obs_err;
  logic        obs_hwrite1;
  logic [31:0] obs_hwdata2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk1({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, "_htrans"}, 32'(HTRANS), 32'd0);
    chk({tag, "_haddr"}, HADDR, 32'd0);
    chk1({tag, "_hwrite"}, HWRITE, 1'b0);
    chk({tag, "_hwdata"}, HWDATA, 32'd0);
    chk1({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk1({tag, "_rsp_err"}, rsp_err, 1'b0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk1("idle_cmd_ready", cmd_ready, 1'b1);
      chk("idle_htrans", 32'(HTRANS), 32'd0);
      chk1("idle_rsp_valid", rsp_valid, 1'b0);
      chk("idle_haddr", HADDR, m_haddr);
      chk1("idle_hwrite", HWRITE, m_hwrite);
      cmd_valid = 1'b0;
      cmd_addr  = $urandom;
      rsp_ready = 1'($urandom);
      HREADY    = 1'($urandom);
      HRESP     = 1'($urandom);
      HRDATA    = $urandom;
    end
  endtask

  // One command from acceptance to response handshake. a/d are the number of
  // HREADY-low cycles in the address/data phase, h the response hold, and
  // hresp_bits[k] the HRESP value on the k-th data-phase cycle. abort_at>0
  // asserts reset in that cycle instead of finishing.
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input int a, input int d, input int h,
                         input logic [31:0] hresp_bits, input bit fix_rd,
                         input logic [31:0] rd_val, input int abort_at);
    bit mis, in_addr, in_data, in_resp, exp_err;
    int addr_last, data_first, data_last, resp_start, c_end;
    logic [31:0] exp_rdata;
    mis        = (addr[1:0] != 2'b00);
    addr_last  = 0;
    data_first = 0;
    data_last  = -1;
    exp_err    = 1'b0;
    exp_rdata  = '0;
    if (mis) begin
      resp_start = 1;
      exp_err    = 1'b1;
    end else begin
      addr_last  = a + 1;
      data_first = a + 2;
      data_last  = a + 2 + d;
      resp_start = a + d + 3;
`ifdef AHB_MASTER_TIMEOUT_EN
      if (a >= TMO) begin
        addr_last  = TMO;
        data_last  = -1;
        resp_start = TMO + 1;
        exp_err    = 1'b1;
      end else if (d >= TMO) begin
        data_last  = a + 1 + TMO;
        resp_start = a + 2 + TMO;
        exp_err    = 1'b1;
      end
`endif
    end
    c_end = resp_start + h;

    @(negedge clk);
    chk1("accept_cmd_ready", cmd_ready, 1'b1);
    chk("accept_htrans", 32'(HTRANS), 32'd0);
    chk1("accept_rsp_valid", rsp_valid, 1'b0);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_write = wr;
    cmd_wdata = wd;
    HREADY    = 1'($urandom);
    HRESP     = 1'($urandom);
    HRDATA    = $urandom;
    rsp_ready = 1'($urandom);
    if (!mis) begin
      m_haddr  = addr;
      m_hwrite = wr;
    end
    obs_lat = -1; obs_trans = 0; obs_valid = 0;
    obs_rdata = '0; obs_err = 1'b0; obs_hwrite1 = 1'b0; obs_hwdata2 = '0;

    for (int c = 1; c <= c_end; c++) begin
      @(negedge clk);
      in_addr = !mis && (c <= addr_last);
      in_data = (c >= data_first) && (c <= data_last);
      in_resp = (c >= resp_start);
      chk1("busy_cmd_ready", cmd_ready, 1'b0);
      chk("htrans", 32'(HTRANS), in_addr ? 32'd2 : 32'd0);
      chk("haddr", HADDR, m_haddr);
      chk1("hwrite", HWRITE, m_hwrite);
      if (in_data) chk("hwdata", HWDATA, wr ? wd : 32'd0);
      chk1("rsp_valid", rsp_valid, in_resp);
      if (in_resp) begin
        chk1("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rdata);
      end
      if (c == abort_at) begin
        rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        m_haddr  = '0;
        m_hwrite = 1'b0;
        return;
      end
      if (HTRANS == 2'b10) obs_trans++;
      if (rsp_valid) begin
        obs_valid++;
        if (obs_lat < 0) begin
          obs_lat   = c;
          obs_rdata = rsp_rdata;
          obs_err   = rsp_err;
        end
      end
      if (c == 1) obs_hwrite1 = HWRITE;
      if (c == 2) obs_hwdata2 = HWDATA;

      cmd_valid = 1'($urandom);
      cmd_addr  = $urandom;
      cmd_write = 1'($urandom);
      cmd_wdata = $urandom;
      HRDATA    = fix_rd ? rd_val : $urandom;
      HRESP     = 1'($urandom);
      HREADY    = 1'($urandom);
      if (in_addr) HREADY = (c == a + 1);
      if (in_data) begin
        HREADY = (c == a + 2 + d);
        HRESP  = (c - data_first < 32) ? hresp_bits[c - data_first] : 1'b0;
        if (HRESP) exp_err = 1'b1;
        if (HREADY && !exp_err && !wr) exp_rdata = HRDATA;
      end
      rsp_ready = in_resp ? (c >= resp_start + h) : 1'($urandom);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  logic [31:0] ra, hb;

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
    rsp_ready = 1'b0; HRDATA = '0; HREADY = 1'b0; HRESP = 1'b0;
    m_haddr = '0; m_hwrite = 1'b0;
    #1;
    reset_checks("por");
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

    // Write, zero wait states.
    run_txn(32'h1000_0004, 1'b1, 32'hDEAD_BEEF, 0, 0, 0, 32'd0, 1'b0, 32'd0, 0);
    chk("wr_latency", 32'(obs_lat), 32'd3);
    chk1("wr_err", obs_err, 1'b0);
    chk("wr_ntrans", 32'(obs_trans), 32'd1);
    chk("wr_hwdata", obs_hwdata2, 32'hDEAD_BEEF);
    chk("wr_rdata", obs_rdata, 32'd0);

    // Read, slave returns a fixed word.
    run_txn(32'h1000_0004, 1'b0, 32'h1234_5678, 0, 0, 1, 32'd0, 1'b1, 32'hDEAD_BEEF, 0);
    chk("rd_rdata", obs_rdata, 32'hDEAD_BEEF);
    chk1("rd_err", obs_err, 1'b0);
    chk1("rd_hwrite", obs_hwrite1, 1'b0);
    chk("rd_latency", 32'(obs_lat), 32'd3);

    // Three data-phase wait states.
    run_txn(32'h2000_0010, 1'b1, 32'hCAFE_F00D, 0, 3, 0, 32'd0, 1'b0, 32'd0, 0);
    chk("ws_latency", 32'(obs_lat), 32'd6);
    chk("ws_hwdata", obs_hwdata2, 32'hCAFE_F00D);

    // Two-cycle error response on a read.
    run_txn(32'h2000_0020, 1'b0, 32'd0, 0, 1, 0, 32'b11, 1'b1, 32'hA5A5_A5A5, 0);
    chk1("err_err", obs_err, 1'b1);
    chk("err_rdata", obs_rdata, 32'd0);
    chk("err_latency", 32'(obs_lat), 32'd4);

    // Misaligned address: no bus transfer, immediate error.
    run_txn(32'h0000_0002, 1'b0, 32'd0, 0, 0, 0, 32'd0, 1'b0, 32'd0, 0);
    chk("mis_latency", 32'(obs_lat), 32'd1);
    chk1("mis_err", obs_err, 1'b1);
    chk("mis_ntrans", 32'(obs_trans), 32'd0);
    chk("mis_rdata", obs_rdata, 32'd0);

    // Response back-pressure for 5 cycles.
    run_txn(32'h3000_0008, 1'b0, 32'd0, 1, 0, 5, 32'd0, 1'b1, 32'h0F0F_1234, 0);
    chk("bp_valid_cycles", 32'(obs_valid), 32'd6);
    chk("bp_rdata", obs_rdata, 32'h0F0F_1234);

    // Long address-phase stall.
    run_txn(32'h4000_0000, 1'b1, 32'h5555_AAAA, 20, 0, 0, 32'd0, 1'b0, 32'd0, 0);
`ifdef AHB_MASTER_TIMEOUT_EN
    chk("tmo_latency", 32'(obs_lat), 32'd17);
    chk1("tmo_err", obs_err, 1'b1);
`else
    chk("stall_latency", 32'(obs_lat), 32'd23);
    chk1("stall_err", obs_err, 1'b0);
`endif

    // Reset during the data phase: no response afterwards.
    run_txn(32'h5000_0000, 1'b1, 32'h0BAD_F00D, 0, 5, 0, 32'd0, 1'b0, 32'd0, 3);
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    idle_cycles(4);

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 5) != 0) ra[1:0] = 2'b00;
      hb = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
      run_txn(ra, 1'($urandom), $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), hb, 1'b0, 32'd0, 0);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
